// File: rtl/bf16_stream_accumulator.sv
// Multi-cycle bf16 accumulator: sums a valid/ready stream of bf16 products per group
// (closed by in_last) and presents the round-to-nearest-even result on an output handshake.
module bf16_stream_accumulator #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int BIAS  = 127
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data
);

    localparam int DW    = 1 + EXP_W + MAN_W;
    localparam int MAG_W = EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam int SUM_W = EXT_W + 1;
    localparam logic [EXP_W:0] MAX_EXP = (EXP_W+1)'(2 * BIAS);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     acc_q, acc_d, op_q, op_d, out_data_q, out_data_d;
    logic              last_q, last_d, sub_q, sub_d, sign_q, sign_d;
    logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [EXT_W-1:0]  big_q, big_d, small_q, small_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [EXP_W:0]    exp_q, exp_d;

    logic [MAG_W-1:0]  a_mag_s, b_mag_s, big_mag_s, small_mag_s;
    logic              swap_s, round_up_s;
    logic [EXP_W-1:0]  diff_s;
    logic [EXT_W-1:0]  small_sig_s, mask_s, shifted_s;
    logic [SUM_W-1:0]  add_s;
    logic [MAN_W:0]    rnd_s;
    logic [EXP_W:0]    rnd_exp_s;

    // Arithmetic datapath: operand ordering/alignment, add/subtract, rounding increment
    always_comb begin
        a_mag_s = (acc_q[DW-2:MAN_W] == {EXP_W{1'b0}}) ? {MAG_W{1'b0}} : acc_q[MAG_W-1:0];
        b_mag_s = (op_q[DW-2:MAN_W] == {EXP_W{1'b0}}) ? {MAG_W{1'b0}} : op_q[MAG_W-1:0];
        swap_s      = (b_mag_s > a_mag_s);
        big_mag_s   = swap_s ? b_mag_s : a_mag_s;
        small_mag_s = swap_s ? a_mag_s : b_mag_s;
        diff_s      = big_mag_s[MAG_W-1:MAN_W] - small_mag_s[MAG_W-1:MAN_W];
        small_sig_s = {|small_mag_s[MAG_W-1:MAN_W], small_mag_s[MAN_W-1:0], 3'b000};
        mask_s      = (EXT_W'(1) << diff_s) - EXT_W'(1);
        if (diff_s >= EXP_W'(EXT_W)) begin
            shifted_s = {{(EXT_W-1){1'b0}}, |small_sig_s};
        end else begin
            shifted_s = (small_sig_s >> diff_s) | {{(EXT_W-1){1'b0}}, |(small_sig_s & mask_s)};
        end
        add_s = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        // Bits [2:0] are guard/round/sticky; bit 3 is the mantissa LSB for tie-to-even.
        round_up_s = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        rnd_s      = {1'b0, sum_q[EXT_W-2:3]} + {{MAN_W{1'b0}}, round_up_s};
        rnd_exp_s  = exp_q + {{EXP_W{1'b0}}, rnd_s[MAN_W]};
    end

    // Next-state and registered-output computation for the sequencing FSM
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        last_d  = last_q;
        sub_d   = sub_q;
        sign_d  = sign_q;
        big_d   = big_q;
        small_d = small_q;
        sum_d   = sum_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_data;
                    last_d  = in_last;
                    state_d = ALIGN;
                end else begin
                    state_d = IDLE;
                end
            end
            ALIGN: begin
                big_d   = {|big_mag_s[MAG_W-1:MAN_W], big_mag_s[MAN_W-1:0], 3'b000};
                small_d = shifted_s;
                exp_d   = {1'b0, big_mag_s[MAG_W-1:MAN_W]};
                sign_d  = swap_s ? op_q[DW-1] : acc_q[DW-1];
                sub_d   = acc_q[DW-1] ^ op_q[DW-1];
                state_d = ADD;
            end
            ADD: begin
                if (sub_q && (add_s == {SUM_W{1'b0}})) begin
                    acc_d   = {DW{1'b0}};
                    state_d = last_q ? DONE : IDLE;
                end else begin
                    sum_d   = add_s;
                    state_d = (add_s[SUM_W-1] || !add_s[EXT_W-1]) ? NORM : ROUND;
                end
            end
            NORM: begin
                if (sum_q[SUM_W-1]) begin
                    sum_d   = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + (EXP_W+1)'(1);
                    state_d = ROUND;
                end else if (sum_q[EXT_W-1]) begin
                    state_d = ROUND;
                end else if (exp_q <= (EXP_W+1)'(1)) begin
                    // Further left shifts would push the exponent to zero: flush.
                    acc_d   = {DW{1'b0}};
                    state_d = last_q ? DONE : IDLE;
                end else begin
                    sum_d   = {sum_q[SUM_W-2:0], 1'b0};
                    exp_d   = exp_q - (EXP_W+1)'(1);
                    state_d = sum_q[EXT_W-2] ? ROUND : NORM;
                end
            end
            ROUND: begin
                if (rnd_exp_s > MAX_EXP) begin
                    acc_d = {sign_q, MAX_EXP[EXP_W-1:0], {MAN_W{1'b1}}};
                end else begin
                    acc_d = {sign_q, rnd_exp_s[EXP_W-1:0], rnd_s[MAN_W-1:0]};
                end
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = {DW{1'b0}};
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        out_data_d  = (state_d == DONE) ? acc_d : {DW{1'b0}};
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= {DW{1'b0}};
            op_q        <= {DW{1'b0}};
            last_q      <= 1'b0;
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            big_q       <= {EXT_W{1'b0}};
            small_q     <= {EXT_W{1'b0}};
            sum_q       <= {SUM_W{1'b0}};
            exp_q       <= {(EXP_W+1){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            last_q      <= last_d;
            sub_q       <= sub_d;
            sign_q      <= sign_d;
            big_q       <= big_d;
            small_q     <= small_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_bf16_stream_accumulator.sv
// Self-checking bench for bf16_stream_accumulator: directed corner cases plus random
// groups checked against a real-arithmetic reference with round-to-nearest-even.
module tb_bf16_stream_accumulator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;

    bf16_stream_accumulator dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) begin
            repeat (e) r = r * 2.0;
        end else begin
            repeat (-e) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real bf_val(input logic [15:0] h);
        int  ex = int'(h[14:7]);
        int  mm = int'(h[6:0]);
        real r;
        if (ex == 0) return 0.0;
        r = (128.0 + real'(mm)) / 128.0 * pow2(ex - 127);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] to_bf(input real x);
        logic s;
        real  a;
        real  m;
        real  frac;
        int   e = 0;
        int   mi;
        int   be;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        a = s ? -x : x;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m    = a * 128.0;
        mi   = int'($floor(m));
        frac = m - real'(mi);
        if (frac > 0.5 || (frac == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 256) begin mi = 128; e++; end
        be = e + 127;
        if (be <= 0) return 16'h0000;
        if (be > 254) return {s, 8'hFE, 7'h7F};
        return {s, be[7:0], mi[6:0]};
    endfunction

    task automatic send(input logic [15:0] d, input logic l);
        int w = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) check_eq("send_in_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic take(input string tag, input logic [15:0] exp, input int hold);
        int w = 0;
        while (!out_valid && w < 400) begin
            @(negedge clock);
            w++;
        end
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq(tag, out_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check_eq({tag, "_hold"}, {out_valid, in_ready, out_data}, {1'b1, 1'b0, exp});
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_taken"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [15:0] acc_m;
        logic [15:0] x;
        int          n;
        int          lat;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("reset_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 16'h0000});
        reset_n = 1'b1;

        // 1.0 + 2.0, stray out_ready while idle-side busy, held result
        send(16'h3F80, 1'b0);
        @(negedge clock);
        check_eq("busy_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check_eq("stray_out_ready", out_valid, 1'b0);
        send(16'h4000, 1'b1);
        @(negedge clock);
        check_eq("busy_in_ready2", in_ready, 1'b0);
        take("sum_1p2", 16'h4040, 5);

        send(16'h3F80, 1'b0);
        send(16'hBF80, 1'b1);
        take("cancel", 16'h0000, 0);
        send(16'h4000, 1'b1);
        take("after_cancel", 16'h4000, 0);

        send(16'h3F81, 1'b0);
        send(16'hBF80, 1'b1);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clock);
            if (!out_valid) lat++;
        end
        check_eq("norm_latency", lat, 11);
        take("norm7", 16'h3C00, 0);

        send(16'h3F80, 1'b0);
        send(16'h3B80, 1'b1);
        take("tie_even", 16'h3F80, 0);
        send(16'h3F81, 1'b0);
        send(16'h3B80, 1'b1);
        take("tie_up", 16'h3F82, 0);

        send(16'h7F7F, 1'b0);
        send(16'h7F7F, 1'b1);
        take("saturate", 16'h7F7F, 0);
        send(16'h0055, 1'b0);
        send(16'h4040, 1'b1);
        take("flush_sub", 16'h4040, 0);

        // Reset pulse while the second element is normalising
        send(16'h3F81, 1'b0);
        send(16'hBF80, 1'b1);
        repeat (3) @(negedge clock);
        check_eq("pre_reset_busy", in_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 16'h0000});
        @(negedge clock);
        reset_n = 1'b1;
        send(16'h3F80, 1'b1);
        take("post_reset", 16'h3F80, 0);

        for (int g = 0; g < 30; g++) begin
            n     = int'($urandom_range(5, 1));
            acc_m = 16'h0000;
            for (int k = 0; k < n; k++) begin
                if (acc_m != 16'h0000 && $urandom_range(5, 0) == 0) begin
                    x = acc_m ^ 16'h8000;
                end else begin
                    x[15]   = 1'($urandom_range(1, 0));
                    x[14:7] = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom_range(150, 100));
                    x[6:0]  = 7'($urandom);
                end
                acc_m = to_bf(bf_val(acc_m) + bf_val(x));
                repeat ($urandom_range(2, 0)) @(negedge clock);
                send(x, (k == n - 1));
            end
            take("rand", acc_m, int'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
